grytobin: RTL

Bit-serial Gray-to-binary converter. It sits directly downstream of the `bintogry` stage and accepts a WIDTH-bit Gray code word on a one-cycle strobe. It rebuilds the binary value MSB-first, one bit per clock, then presents it with a one-cycle valid pulse. It also checks that each accepted code differs from the previously accepted one by exactly one bit, flags violations, and counts strobes dropped while busy.

---
 rtl/grytobin.sv | 112 +++++++++++
 1 files changed

// File: rtl/grytobin.sv
// grytobin: bit-serial Gray-to-binary converter.
// It accepts a Gray word on a one-cycle strobe and rebuilds the binary value
// MSB-first, one bit per clock. It then presents the result with a one-cycle
// valid pulse. It also checks that successive accepted codes differ in exactly
// one bit, and it counts strobes that arrive while a conversion is running.
module grytobin #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] datagry,
    input  logic             gry_vld,
    output logic [WIDTH-1:0] databin,
    output logic             bin_vld,
    output logic             busy,
    output logic             step_err,
    output logic [7:0]       drop_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] gry_r;
    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] prev_gry;
    logic             first;

    logic [IW-1:0]    idx_up;
    logic             bit_next;
    logic [WIDTH-1:0] diff;
    logic             one_hot;

    // Next binary bit for position idx, and the single-bit-step check on the held code.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        idx_up   = idx + IW'(1);
        bit_next = gry_r[idx];
        if (idx != MSB_IDX) begin
            bit_next = gry_r[idx] ^ bin_r[idx_up];
        end
        diff    = gry_r ^ prev_gry;
        // A value is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
        one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    end

    // Conversion FSM: capture the word, build one bit per clock, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are few, so all of them are reset. A reset mid-conversion
        // then leaves no stale partial result and re-arms the first-word exemption.
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            gry_r    <= '0;
            bin_r    <= '0;
            prev_gry <= '0;
            first    <= 1'b1;
            databin  <= '0;
            bin_vld  <= 1'b0;
            step_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            bin_vld  <= 1'b0;
            step_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (gry_vld) begin
                        gry_r <= datagry;
                        idx   <= MSB_IDX;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bin_r[idx] <= bit_next;
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    databin  <= bin_r;
                    bin_vld  <= 1'b1;
                    step_err <= first ? 1'b0 : !one_hot;
                    prev_gry <= gry_r;
                    first    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of strobes that arrive while a conversion is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (gry_vld && (state != IDLE) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule
